// File: rtl/note_stabilizer.sv
// Pitch-code conditioner: sanitizes raw estimates, commits a note only after a stable run,
// and falls back to rest after a long stretch without a sounding sample.
module note_stabilizer #(
  parameter int STABLE_COUNT   = 4,
  parameter int SILENCE_CYCLES = 18562500
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic       toggle_in,
  input  logic       raw_valid_in,
  input  logic [5:0] raw_note_in,
  output logic [5:0] note_out,
  output logic       note_change_out,
  output logic       stable_out
);

  localparam int              SIL_W   = $clog2(SILENCE_CYCLES + 1);
  localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(SILENCE_CYCLES);
  localparam logic [3:0]       STABLE  = 4'(STABLE_COUNT);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t           state, state_nxt;
  logic [5:0]       s, cand, cand_nxt, note_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [SIL_W-1:0] sil, sil_nxt;
  logic             change_nxt, stable_nxt;

  // Anything outside the chromatic window, including the no-note codes, reads as rest.
  assign s = (raw_note_in >= 6'h20 && raw_note_in <= 6'h35) ? raw_note_in : 6'h00;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = toggle_in ? TRACK : IDLE;
  end

  always_comb begin
    cand_nxt   = 6'h00;
    cnt_nxt    = 4'd0;
    sil_nxt    = '0;
    note_nxt   = 6'h00;
    change_nxt = 1'b0;
    stable_nxt = 1'b0;
    if (state == TRACK && toggle_in) begin
      cand_nxt = cand;
      cnt_nxt  = cnt;
      note_nxt = note_out;
      if (raw_valid_in && s != 6'h00) sil_nxt = '0;
      else if (sil == SIL_MAX)        sil_nxt = sil;
      else                            sil_nxt = sil + 1'b1;

      // Timeout forcing repeats while saturated; a sounding sample clears sil first, so it wins.
      if (sil_nxt == SIL_MAX) begin
        cand_nxt   = 6'h00;
        cnt_nxt    = 4'd0;
        note_nxt   = 6'h00;
        change_nxt = (note_out != 6'h00);
      end else begin
        if (raw_valid_in) begin
          if (s == cand) begin
            cnt_nxt = (cnt == 4'd15) ? cnt : cnt + 4'd1;
          end else begin
            cand_nxt = s;
            cnt_nxt  = 4'd1;
          end
        end
        if (cnt_nxt >= STABLE && cand_nxt != note_out) begin
          note_nxt   = cand_nxt;
          change_nxt = 1'b1;
        end
      end
      stable_nxt = (cnt_nxt >= STABLE) && (cand_nxt == note_nxt);
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      cand            <= 6'h00;
      cnt             <= 4'd0;
      sil             <= '0;
      note_out        <= 6'h00;
      note_change_out <= 1'b0;
      stable_out      <= 1'b0;
    end else begin
      cand            <= cand_nxt;
      cnt             <= cnt_nxt;
      sil             <= sil_nxt;
      note_out        <= note_nxt;
      note_change_out <= change_nxt;
      stable_out      <= stable_nxt;
    end
  end

endmodule

// File: tb/tb_note_stabilizer.sv
// Bench for note_stabilizer: directed scenarios plus random traffic, all checked against
// a history-based reference model of the note commit and silence rules.
module tb_note_stabilizer;

  localparam int STABLE = 4;
  localparam int SIL    = 100;

  logic       clk = 1'b0;
  logic       rst, tog, vld;
  logic [5:0] raw;
  logic [5:0] note_out;
  logic       note_change_out, stable_out;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit         m_track;
  logic [5:0] hist[$];
  int         quiet;
  logic [5:0] m_note;
  bit         m_change, m_stable;

  note_stabilizer #(.STABLE_COUNT(STABLE), .SILENCE_CYCLES(SIL)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .toggle_in(tog), .raw_valid_in(vld),
    .raw_note_in(raw), .note_out(note_out), .note_change_out(note_change_out),
    .stable_out(stable_out)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sanitize(input logic [5:0] r);
    return (r[5] && r <= 6'h35) ? r : 6'h00;
  endfunction

  task automatic model_step();
    logic [5:0] sv, c;
    int run;
    m_change = 0;
    if (rst || !tog) begin
      m_track = 0; hist.delete(); quiet = 0; m_note = 0; m_stable = 0;
      return;
    end
    if (!m_track) begin
      m_track = 1; m_stable = 0;
      return;
    end
    sv = sanitize(raw);
    if (vld && sv != 0) quiet = 0;
    else if (quiet < SIL) quiet++;
    if (quiet == SIL) begin
      hist.delete();
      if (m_note != 0) m_change = 1;
      m_note = 0;
    end else if (vld) begin
      hist.push_back(sv);
      if (hist.size() > 20) void'(hist.pop_front());
    end
    run = 0;
    c = (hist.size() > 0) ? hist[hist.size()-1] : 6'h00;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == c) run++;
      else break;
    end
    if (quiet != SIL && run >= STABLE && c != m_note) begin
      m_note = c; m_change = 1;
    end
    m_stable = (run >= STABLE) && (c == m_note);
  endtask

  task automatic tick(input logic v, input logic [5:0] r);
    vld = v; raw = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_run();
    tog = 0; tick(0, 0);
    tog = 1; tick(0, 0);
  endtask

  task automatic test_reset();
    rst = 1; tog = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1, 6'h20);
      tests++;
      if ({note_out, note_change_out, stable_out} !== 8'h00) begin
        fails++; $display("FAIL reset_outputs got %h/%b/%b want 00/0/0", note_out, note_change_out, stable_out);
      end
    end
    rst = 0; tick(1, 6'h20);
    tests++;
    if (note_out !== 6'h00 || note_change_out !== 1'b0) begin
      fails++; $display("FAIL reset_release got %h/%b want 00/0", note_out, note_change_out);
    end
  endtask

  task automatic test_commit();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 6'h20);
      pulses += note_change_out;
      tests++;
      if ({note_out, note_change_out, stable_out} !== {m_note, m_change, m_stable}) begin
        fails++; $display("FAIL commit_model i=%0d got %h/%b/%b want %h/%b/%b", i, note_out,
                          note_change_out, stable_out, m_note, m_change, m_stable);
      end
      if (i == 3) begin
        tests++;
        if (note_out !== 6'h20 || note_change_out !== 1'b1 || stable_out !== 1'b1) begin
          fails++; $display("FAIL commit_4th got %h/%b/%b want 20/1/1", note_out, note_change_out, stable_out);
        end
      end
      tick(0, 0);
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL commit_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    logic [5:0] seq[7] = '{6'h29, 6'h29, 6'h2B, 6'h29, 6'h29, 6'h29, 6'h29};
    clear_run();
    for (int i = 0; i < 7; i++) begin
      tick(1, seq[i]);
      tests++;
      if (note_out !== ((i == 6) ? 6'h29 : 6'h00) || note_change_out !== (i == 6)) begin
        fails++; $display("FAIL glitch i=%0d got %h/%b want %h/%b", i, note_out, note_change_out,
                          (i == 6) ? 6'h29 : 6'h00, i == 6);
      end
    end
  endtask

  task automatic test_range();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(1, 6'h3F); pulses += note_change_out; end
    tests++;
    if (note_out !== 6'h00 || pulses != 1) begin
      fails++; $display("FAIL range_3f got %h pulses %0d want 00 pulses 1", note_out, pulses);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(1, 6'h15); pulses += note_change_out; end
    tests++;
    if (note_out !== 6'h00 || pulses != 0 || stable_out !== 1'b1) begin
      fails++; $display("FAIL range_15 got %h pulses %0d stable %b want 00 0 1", note_out, pulses, stable_out);
    end
  endtask

  task automatic test_silence();
    clear_run();
    for (int i = 0; i < 4; i++) tick(1, 6'h2C);
    for (int i = 1; i <= SIL + 3; i++) begin
      tick(0, 0);
      if (i == SIL - 1 || i == SIL || i == SIL + 2) begin
        tests++;
        if (note_out !== ((i >= SIL) ? 6'h00 : 6'h2C) || note_change_out !== (i == SIL)) begin
          fails++; $display("FAIL silence_timeout t=%0d got %h/%b want %h/%b", i, note_out,
                            note_change_out, (i >= SIL) ? 6'h00 : 6'h2C, i == SIL);
        end
      end
    end
    for (int i = 0; i < 4; i++) tick(1, 6'h2C);
    for (int i = 1; i < SIL; i++) tick(0, 0);
    tick(1, 6'h2C);
    tests++;
    if (note_out !== 6'h2C || note_change_out !== 1'b0) begin
      fails++; $display("FAIL silence_sample_wins got %h/%b want 2c/0", note_out, note_change_out);
    end
    tick(0, 0);
    tests++;
    if (note_out !== 6'h2C) begin
      fails++; $display("FAIL silence_after_win got %h want 2c", note_out);
    end
  endtask

  task automatic test_toggle();
    clear_run();
    tick(1, 6'h2E); tick(1, 6'h2E);
    tog = 0; tick(1, 6'h2E);
    tog = 1; tick(0, 0);
    tick(1, 6'h2E); tick(1, 6'h2E);
    tests++;
    if (note_out !== 6'h00 || note_change_out !== 1'b0) begin
      fails++; $display("FAIL toggle_restart got %h/%b want 00/0", note_out, note_change_out);
    end
    tick(1, 6'h2E); tick(1, 6'h2E);
    tests++;
    if (note_out !== 6'h2E || note_change_out !== 1'b1) begin
      fails++; $display("FAIL toggle_commit got %h/%b want 2e/1", note_out, note_change_out);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[6] = '{6'h20, 6'h2A, 6'h35, 6'h36, 6'h11, 6'h00};
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      tog = ($urandom_range(0, 79) != 0);
      if (i >= 1500 && i < 1650) tick(0, pool[$urandom_range(0, 5)]);
      else tick($urandom_range(0, 2) != 0, pool[$urandom_range(0, 5)]);
      tests++;
      if ({note_out, note_change_out, stable_out} !== {m_note, m_change, m_stable}) begin
        fails++;
        if (bad++ < 10)
          $display("FAIL random i=%0d got %h/%b/%b want %h/%b/%b", i, note_out, note_change_out,
                   stable_out, m_note, m_change, m_stable);
      end
    end
    rst = 0; tog = 1;
  endtask

  initial begin
    rst = 1; tog = 0; vld = 0; raw = 0;
    m_track = 0; quiet = 0; m_note = 0; m_change = 0; m_stable = 0;
    test_reset();
    test_commit();
    test_glitch();
    test_range();
    test_silence();
    test_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
